led_step_ctrl: RTL

Step-rate controller that sits directly upstream of the 4-LED chaser and paces its pattern. It debounces a raw active-low push key, cycles through four speed settings on each press, and emits a single-cycle `step_en` pulse at the selected rate. The chaser advances one position per `step_en`, giving a visible, user-adjustable chase speed.

---
 rtl/led_pkg.sv | 11 +
 rtl/led_step_ctrl_if.sv | 14 +
 rtl/led_step_ctrl_key_debounce.sv | 78 +++++++
 rtl/led_step_ctrl.sv | 63 ++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types for the LED chaser pacing logic: speed index and key debouncer states.
package led_pkg;

   typedef logic [1:0] led_speed_t;

   localparam led_speed_t LED_SPEED_SLOW = 2'd0;
   localparam led_speed_t LED_SPEED_FAST = 2'd3;

   typedef enum logic [1:0] {UP, WAIT_DN, DOWN, WAIT_UP} key_db_state_t;

endpackage

// File: rtl/led_step_ctrl_if.sv
// Key/run inputs and step/speed outputs of the step-rate controller; master drives key and run.
interface led_step_ctrl_if;
   import led_pkg::*;

   logic       key_n;
   logic       run_en;
   logic       step_en;
   logic       key_press;
   led_speed_t speed;

   modport master (output key_n, run_en, input step_en, key_press, speed);
   modport slave  (input key_n, run_en, output step_en, key_press, speed);

endinterface

// File: rtl/led_step_ctrl_key_debounce.sv
// Two-flop synchronizer plus debounce FSM; key_press pulses DEBOUNCE_CYCLES+2 cycles after key goes low.
// press_next is the combinational look-ahead of key_press, asserted the cycle before it.
module key_debounce
   import led_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic key_press,
   output logic press_next
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync;
   logic             key_s;
   key_db_state_t    state;
   logic [CNT_W-1:0] cnt;

   assign key_s      = sync[1];
   assign press_next = (state == WAIT_DN) && !key_s && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         sync      <= 2'b11;
         state     <= UP;
         cnt       <= '0;
         key_press <= 1'b0;
      end else begin
         sync      <= {sync[0], key_n};
         key_press <= press_next;
         case (state)
            UP: begin
               if (!key_s) begin
                  state <= WAIT_DN;
                  cnt   <= CNT_W'(1);
               end
            end
            WAIT_DN: begin
               if (key_s) begin
                  state <= UP;
                  cnt   <= '0;
               end else if (cnt == LAST) begin
                  state <= DOWN;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DOWN: begin
               if (key_s) begin
                  state <= WAIT_UP;
                  cnt   <= CNT_W'(1);
               end
            end
            WAIT_UP: begin
               if (!key_s) begin
                  state <= DOWN;
                  cnt   <= '0;
               end else if (cnt == LAST) begin
                  state <= UP;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= UP;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/led_step_ctrl.sv
// Paces the LED chaser: debounced key cycles four speeds, prescaler emits one step_en per period.
// step_en is registered one cycle ahead so it is high in the same cycle the count sits at P-1.
module led_step_ctrl
   import led_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned BASE_DIV        = 6_250_000
) (
   input  logic            clk,
   input  logic            rst,
   led_step_ctrl_if.slave  bus
);

   localparam int unsigned CNT_W = $clog2(8 * BASE_DIV);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] per_m1;
   led_speed_t       speed;
   logic             step_en;
   logic             key_press;
   logic             press_next;

   key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_key (
      .clk        (clk),
      .rst        (rst),
      .key_n      (bus.key_n),
      .key_press  (key_press),
      .press_next (press_next)
   );

   assign per_m1 = CNT_W'((BASE_DIV << (LED_SPEED_FAST - speed)) - 1);

   always_comb begin
      cnt_nxt = cnt;
      if (bus.run_en) begin
         cnt_nxt = (cnt >= per_m1) ? '0 : cnt + CNT_W'(1);
      end
   end

   // A speed change restarts the period; press_next keeps step_en low in the key_press cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         speed   <= LED_SPEED_SLOW;
         cnt     <= '0;
         step_en <= 1'b0;
      end else if (key_press) begin
         speed   <= speed + 2'd1;
         cnt     <= '0;
         step_en <= 1'b0;
      end else begin
         cnt     <= cnt_nxt;
         step_en <= bus.run_en && !press_next && (cnt_nxt == per_m1);
      end
   end

   assign bus.step_en   = step_en;
   assign bus.key_press = key_press;
   assign bus.speed     = speed;

endmodule
